// File: rtl/a2con_rx_fifo.sv
// a2con_rx_fifo: Apple II console byte FIFO feeding the CPU RBUF/RCSR receive path.
// Optional A2CON_OVR_CNT_EN compiles in the sticky overrun flag and dropped-byte counter.
module a2con_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_x3,
  input  logic                     rstb,
  input  logic                     flush,
  input  logic                     wr_stb,
  input  logic [7:0]               wr_data,
  input  logic                     rd_req,
  output logic [7:0]               rd_data,
  output logic                     rdone,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovr,
  output logic [7:0]               ovr_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_req_q, rdone_q, full_q, pop, push, drop;
  always_comb begin
    pop       = rd_req & ~rd_req_q & rdone_q;
    push      = wr_stb & (~full_q | pop);
    drop      = wr_stb & full_q & ~pop;
    rd_ptr_nx = rd_ptr_q + 1'b1;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_nx : rd_ptr_q;
    level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
    // Head register follows the new head; an emptying pop leaves the last byte visible.
    rd_data_d = pop ? (level_q > (AW+1)'(1) ? mem_q[rd_ptr_nx] : push ? wr_data : rd_data_q)
                    : (push && !rdone_q) ? wr_data : rd_data_q;
  end
  always_ff @(posedge clk_x3)
    if (push && !flush && !rstb) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rdone_q   <= 1'b0;
      full_q    <= 1'b0;
      rd_data_q <= '0;
      rd_req_q  <= 1'b0;
    end else begin
      rd_req_q <= rd_req;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        rdone_q  <= 1'b0;
        full_q   <= 1'b0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        level_q   <= level_d;
        rdone_q   <= level_d != '0;
        full_q    <= level_d == (AW+1)'(DEPTH);
        rd_data_q <= rd_data_d;
      end
    end
  end
`ifdef A2CON_OVR_CNT_EN
  logic       ovr_q;
  logic [7:0] ovr_cnt_q;
  always_ff @(posedge clk_x3) begin
    if (rstb || flush) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      ovr_q     <= ovr_q | drop;
      ovr_cnt_q <= ovr_cnt_q + 8'(drop && ovr_cnt_q != 8'hff);
    end
  end
  assign ovr     = ovr_q;
  assign ovr_cnt = ovr_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign ovr         = 1'b0;
  assign ovr_cnt     = '0;
`endif
  assign rd_data = rd_data_q;
  assign rdone   = rdone_q;
  assign full    = full_q;
  assign level   = level_q;
endmodule

// File: tb/tb_a2con_rx_fifo.sv
// tb_a2con_rx_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_a2con_rx_fifo;
  localparam int DEPTH = 16;
  logic clk_x3 = 1'b0, rstb = 1'b1, flush = 1'b0, wr_stb = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data, ovr_cnt;
  logic rdone, full, ovr;
  logic [$clog2(DEPTH):0] level;
  int checks = 0, failures = 0;
  byte unsigned q[$];
  int m_rd = 0, m_cnt = 0;
  bit m_ovr = 0, m_prev = 0;
`ifdef A2CON_OVR_CNT_EN
  localparam bit OVR_EN = 1;
`else
  localparam bit OVR_EN = 0;
`endif

  a2con_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_x3(clk_x3), .rstb(rstb), .flush(flush), .wr_stb(wr_stb), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data), .rdone(rdone), .full(full), .level(level),
    .ovr(ovr), .ovr_cnt(ovr_cnt)
  );

  always #5 clk_x3 = ~clk_x3;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: the FIFO as a queue, one update per clock using the sampled inputs.
  task automatic model_update();
    bit rise, popping, was_empty;
    if (rstb) begin
      q.delete(); m_rd = 0; m_ovr = 0; m_cnt = 0; m_prev = 0;
    end else if (flush) begin
      q.delete(); m_ovr = 0; m_cnt = 0; m_prev = rd_req;
    end else begin
      rise = rd_req && !m_prev;
      m_prev = rd_req;
      was_empty = q.size() == 0;
      popping = rise && !was_empty;
      if (popping) void'(q.pop_front());
      if (wr_stb && (q.size() < DEPTH)) q.push_back(wr_data);
      else if (wr_stb && OVR_EN) begin
        m_ovr = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if ((popping || was_empty) && q.size() > 0) m_rd = q[0];
    end
  endtask

  task automatic step(input bit r, input bit f, input bit w, input logic [7:0] d, input bit rr);
    rstb = r; flush = f; wr_stb = w; wr_data = d; rd_req = rr;
    @(posedge clk_x3);
    model_update();
    @(negedge clk_x3);
    chk("level", int'(level), q.size());
    chk("rdone", int'(rdone), int'(q.size() != 0));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("rd_data", int'(rd_data), m_rd);
    chk("ovr", int'(ovr), int'(m_ovr));
    chk("ovr_cnt", int'(ovr_cnt), m_cnt);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 8'hAA, 1);
    chk("rst_level", int'(level), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    // Write on first cycle after reset
    step(0, 0, 1, 8'h41, 0);
    chk("w41_rdone", int'(rdone), 1);
    chk("w41_data", int'(rd_data), 8'h41);
    chk("w41_level", int'(level), 1);
    // Three writes, three 4-cycle read pulses
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 8'h31, 0);
    step(0, 0, 1, 8'h32, 0);
    step(0, 0, 1, 8'h33, 0);
    for (int p = 0; p < 3; p++) begin
      chk("seq_data", int'(rd_data), 8'h31 + p);
      for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    chk("seq_empty", int'(rdone), 0);
    chk("seq_hold", int'(rd_data), 8'h33);
    // Overfill by one
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 8'(8'h60 + i), 0);
    chk("ovf_full", int'(full), 1);
    chk("ovf_level", int'(level), 16);
    chk("ovf_ovr", int'(ovr), int'(OVR_EN));
    chk("ovf_cnt", int'(ovr_cnt), OVR_EN ? 1 : 0);
    chk("ovf_head", int'(rd_data), 8'h60);
    // Write coinciding with pop while full
    step(0, 0, 1, 8'h7E, 1);
    chk("fpop_level", int'(level), 16);
    chk("fpop_cnt", int'(ovr_cnt), OVR_EN ? 1 : 0);
    chk("fpop_head", int'(rd_data), 8'h61);
    step(0, 0, 0, 0, 0);
    // Saturating drop counter
    for (int i = 0; i < 260; i++) step(0, 0, 1, 8'(i), 0);
    chk("sat_cnt", int'(ovr_cnt), OVR_EN ? 255 : 0);
    // Flush with rd_req held high, no pop afterwards
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h50 + i), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'hEE, 1);
    chk("fl_level", int'(level), 0);
    chk("fl_rdone", int'(rdone), 0);
    step(0, 0, 1, 8'h99, 1);
    step(0, 0, 0, 0, 1);
    chk("fl_nopop", int'(level), 1);
    chk("fl_data", int'(rd_data), 8'h99);
    // rd_req edge while empty, then a write
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 8'h55, 1);
    step(0, 0, 0, 0, 1);
    chk("emp_level", int'(level), 1);
    chk("emp_rdone", int'(rdone), 1);
    chk("emp_data", int'(rd_data), 8'h55);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
           8'($urandom), $urandom_range(0, 1) == 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a2con_rx_fifo.md
A2CON_RX_FIFO -- requirements
Module: a2con_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 2..256.
REQ-002 SHALL have port clk_x3  input  1  54 MHz system clock; all logic on rising edge.
REQ-003 SHALL have port rstb  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  drain request (CPU RESET instruction, GP code 014), level.
REQ-005 SHALL have port wr_stb  input  1  Apple II byte-write strobe, one-cycle pulse.
REQ-006 SHALL have port wr_data  input  8  Apple II console byte, sampled with wr_stb.
REQ-007 SHALL have port rd_req  input  1  CPU RBUF read in progress, level, several cycles long.
REQ-008 SHALL have port rd_data  output  8  head byte presented as RBUF<7:0>.
REQ-009 SHALL have port rdone  output  1  RCSR<7>: FIFO non-empty.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH entries; Apple II status.
REQ-011 SHALL have port level  output  clog2(DEPTH)+1  current entry count.
REQ-012 SHALL have port ovr  output  1  sticky overrun flag.
REQ-013 SHALL have port ovr_cnt  output  8  saturating dropped-byte count.

Function
REQ-014 SHALL store wr_data at wr_ptr and increment wr_ptr and level when wr_stb=1 and full=0.
REQ-015 SHALL pop exactly once per rd_req assertion, on the cycle after rd_req rises (internal edge detect), if level>0.
REQ-016 SHALL ignore a rd_req rising edge while empty; no pointer or level change; no pop deferred to a later write.
REQ-017 SHALL wrap both pointers modulo DEPTH; level SHALL never exceed DEPTH or drop below 0.
REQ-018 SHALL register rd_data: it equals mem[rd_ptr] one cycle after any write into empty or any pop; when empty it holds the last popped byte.
REQ-019 SHALL perform write and pop in the same cycle with level unchanged; a write while full with a simultaneous pop SHALL be accepted.
REQ-020 SHALL drop a write while full without a simultaneous pop; no pointer change.
REQ-021 SHALL drive rdone = (level!=0) and full = (level==DEPTH), both registered, valid the cycle after the causing event.
REQ-022 SHALL, on flush=1, zero pointers, level, rdone, full, ovr and ovr_cnt in the next cycle; flush overrides same-cycle writes and pops.
REQ-023 SHALL keep flush asserted across multiple cycles equivalent to one flush; writes during flush are discarded.
REQ-024 SHALL hold the rd_req edge detector cleared by flush, so an rd_req level high when flush drops does not pop.

Reset
REQ-025 SHALL, while rstb=1, set pointers, level, rdone, full, ovr, ovr_cnt and rd_data to 0 and clear the rd_req edge detector.
REQ-026 SHALL take precedence over flush, wr_stb and rd_req; no memory clear required.
REQ-027 SHALL accept wr_stb on the first cycle after rstb deasserts.

Configuration
REQ-028 SHALL use macro A2CON_OVR_CNT_EN to compile in overrun tracking.
REQ-029 SHALL, with A2CON_OVR_CNT_EN defined, set ovr on any dropped write (REQ-020) and increment ovr_cnt per dropped byte, saturating at 255.
REQ-030 SHALL, without A2CON_OVR_CNT_EN, tie ovr and ovr_cnt to 0 and keep the ports present.

Verification
REQ-031 SHALL cover: reset, write 0x41 -> rdone=1 and rd_data=0x41 next cycle, level=1.
REQ-032 SHALL cover: 3 writes 0x31,0x32,0x33, then 3 rd_req pulses of 4 cycles each -> rd_data sequence 0x31,0x32,0x33; rdone=0 after the third pop.
REQ-033 SHALL cover: DEPTH=16, 17 writes -> full=1, level=16, 17th byte dropped, ovr=1, ovr_cnt=1 (macro on) or 0 (macro off).
REQ-034 SHALL cover: full FIFO, wr_stb coinciding with the pop cycle -> write accepted, level stays 16, ovr unchanged.
REQ-035 SHALL cover: 5 entries, flush for 3 cycles with rd_req high -> level=0, rdone=0, no pop after flush drops.
REQ-036 SHALL cover: rd_req rising edge while empty, then a write -> level=1, rdone=1, no phantom pop.
